// File: rtl/wave_period_meter.sv
// -----------------------------------------------------------------------------
// wave_period_meter
//
// Measures the period of an incoming square wave as the number of clk cycles
// between consecutive accepted rising edges. The count matches the full-cycle
// period used by the tone generator, so a measured value can be fed straight
// back into it.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   wave_in      asynchronous square-wave input
//   period       last measured period in clk cycles; 0 when silent
//   period_valid one-cycle strobe: period was just updated (measurement or silence)
//   silent       high while no valid periodic input is present
//
// Parameters:
//   MIN_PERIOD   rising edges closer than this (in clk cycles) are glitches
//   MAX_PERIOD   cycles without an accepted rise before the input is declared
//                silent; must be > MIN_PERIOD and < 2^32
// -----------------------------------------------------------------------------
module wave_period_meter #(
    parameter logic [31:0] MIN_PERIOD = 32'd1000,
    parameter logic [31:0] MAX_PERIOD = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wave_in,
    output logic [31:0] period,
    output logic        period_valid,
    output logic        silent
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t      state_r;
    logic        s1_r;
    logic        s2_r;
    logic        s3_r;
    logic [1:0]  warm_r;
    logic [31:0] cnt_r;
    logic        rise_s;

    // Rising edge of the synchronised input. The history flop only holds a
    // genuine sample three cycles after reset; until then a level that was
    // already high at reset release would look like an edge, so it is masked.
    always_comb begin
        rise_s = s2_r & ~s3_r & (warm_r == 2'd3);
    end

    // Synchroniser, warm-up counter and measurement state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r         <= 1'b0;
            s2_r         <= 1'b0;
            s3_r         <= 1'b0;
            warm_r       <= 2'd0;
            cnt_r        <= 32'd0;
            state_r      <= IDLE;
            period       <= 32'd0;
            period_valid <= 1'b0;
            silent       <= 1'b1;
        end else begin
            s1_r <= wave_in;
            s2_r <= s1_r;
            s3_r <= s2_r;

            if (warm_r != 2'd3) begin
                warm_r <= warm_r + 2'd1;
            end else begin
                warm_r <= warm_r;
            end

            // Strobe defaults low; only an update below raises it.
            period_valid <= 1'b0;

            case (state_r)
                IDLE: begin
                    // First edge only establishes the reference point.
                    if (rise_s) begin
                        cnt_r   <= 32'd1;
                        state_r <= MEASURE;
                    end else begin
                        cnt_r   <= 32'd0;
                        state_r <= IDLE;
                    end
                end

                MEASURE: begin
                    // An accepted rise takes precedence over the timeout, so
                    // a rise landing exactly at MAX_PERIOD is still measured.
                    if (rise_s && (cnt_r >= MIN_PERIOD)) begin
                        period       <= cnt_r;
                        period_valid <= 1'b1;
                        silent       <= 1'b0;
                        cnt_r        <= 32'd1;
                        state_r      <= MEASURE;
                    end else if (rise_s) begin
                        // Too close to the reference edge: glitch, keep counting.
                        cnt_r   <= cnt_r + 32'd1;
                        state_r <= MEASURE;
                    end else if (cnt_r >= MAX_PERIOD) begin
                        period       <= 32'd0;
                        period_valid <= 1'b1;
                        silent       <= 1'b1;
                        cnt_r        <= 32'd0;
                        state_r      <= IDLE;
                    end else begin
                        cnt_r   <= cnt_r + 32'd1;
                        state_r <= MEASURE;
                    end
                end

                default: begin
                    cnt_r   <= 32'd0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_period_meter.sv
// -----------------------------------------------------------------------------
// tb_wave_period_meter
//
// Self-checking bench for wave_period_meter with MIN_PERIOD=8, MAX_PERIOD=1000.
// Expected strobes (period, silent) are queued as stimulus edges are driven and
// compared by a monitor whenever period_valid is seen. Unexpected strobes and
// strobes on consecutive cycles are flagged by the monitor as well.
// -----------------------------------------------------------------------------
module tb_wave_period_meter;

    localparam logic [31:0] MIN_P = 32'd8;
    localparam logic [31:0] MAX_P = 32'd1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        wave_in;
    logic [31:0] period;
    logic        period_valid;
    logic        silent;

    typedef struct packed {
        logic [31:0] period;
        logic        silent;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   last_cyc = 0;
    int   prev_cyc = 0;
    logic prev_valid = 1'b0;

    wave_period_meter #(
        .MIN_PERIOD (MIN_P),
        .MAX_PERIOD (MAX_P)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wave_in      (wave_in),
        .period       (period),
        .period_valid (period_valid),
        .silent       (silent)
    );

    // Clock generation
    always #5 clk = ~clk;

    // Cycle counter used to time strobes
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every strobe must match the next queued expectation
    always @(negedge clk) begin
        if (period_valid === 1'b1) begin
            exp_t e;
            prev_cyc = last_cyc;
            last_cyc = cyc;
            checks++;
            if (prev_valid === 1'b1) begin
                errors++;
                $display("FAIL strobe_back_to_back at cycle %0d", cyc);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe period=%0d silent=%0b at cycle %0d",
                         period, silent, cyc);
            end else begin
                e = exp_q.pop_front();
                if (period !== e.period || silent !== e.silent) begin
                    errors++;
                    $display("FAIL strobe_value got period=%0d silent=%0b expected period=%0d silent=%0b",
                             period, silent, e.period, e.silent);
                end
            end
        end
        prev_valid = period_valid;
    end

    task push(input logic [31:0] p, input logic s);
        exp_t e;
        e.period = p;
        e.silent = s;
        exp_q.push_back(e);
    endtask

    // Hold wave_in at a level for n cycles (called at a negedge, returns at one)
    task hold(input logic level, input int n);
        wave_in = level;
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for all queued strobes to arrive
    task drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_strobes got %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task test_reset();
        rst     = 1'b1;
        wave_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) rst = 1'b0;
            @(negedge clk);
            checks++;
            if (period !== 32'd0 || period_valid !== 1'b0 || silent !== 1'b1) begin
                errors++;
                $display("FAIL reset_state cycle %0d got period=%0d valid=%0b silent=%0b expected 0/0/1",
                         i, period, period_valid, silent);
            end
        end
    endtask

    task test_steady();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) push(32'd100, 1'b0);
            hold(1'b1, 50);
            hold(1'b0, 50);
        end
        checks++;
        if (period !== 32'd100 || silent !== 1'b0) begin
            errors++;
            $display("FAIL steady_outputs got period=%0d silent=%0b expected 100/0", period, silent);
        end
    endtask

    task test_glitch();
        for (int i = 0; i < 10; i++) begin
            push(32'd100, 1'b0);
            hold(1'b1, 2);
            hold(1'b0, 2);
            hold(1'b1, 46);
            hold(1'b0, 50);
        end
        checks++;
        if (period !== 32'd100 || silent !== 1'b0) begin
            errors++;
            $display("FAIL glitch_outputs got period=%0d silent=%0b expected 100/0", period, silent);
        end
    endtask

    task test_timeout();
        push(32'd100, 1'b0);
        push(32'd0, 1'b1);
        hold(1'b1, 1200);
        drain("timeout");
        checks++;
        if (last_cyc - prev_cyc != 1000) begin
            errors++;
            $display("FAIL timeout_delay got %0d expected 1000", last_cyc - prev_cyc);
        end
        checks++;
        if (period !== 32'd0 || silent !== 1'b1) begin
            errors++;
            $display("FAIL timeout_outputs got period=%0d silent=%0b expected 0/1", period, silent);
        end
        // Recovery with a 200-cycle wave; the first rise only re-arms.
        hold(1'b0, 100);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) push(32'd200, 1'b0);
            hold(1'b1, 100);
            if (i == 0) begin
                checks++;
                if (silent !== 1'b1) begin
                    errors++;
                    $display("FAIL recovery_first_rise got silent=%0b expected 1", silent);
                end
            end
            hold(1'b0, 100);
        end
        checks++;
        if (period !== 32'd200 || silent !== 1'b0) begin
            errors++;
            $display("FAIL recovery_outputs got period=%0d silent=%0b expected 200/0", period, silent);
        end
    endtask

    task test_boundaries();
        push(32'd200, 1'b0);
        hold(1'b1, 4);
        hold(1'b0, 4);
        push(32'd8, 1'b0);             // spacing exactly MIN: accepted
        hold(1'b1, 4);
        checks++;
        if (period !== 32'd8) begin
            errors++;
            $display("FAIL min_spacing got period=%0d expected 8", period);
        end
        hold(1'b0, 3);
        hold(1'b1, 4);                 // spacing 7: ignored
        checks++;
        if (period !== 32'd8) begin
            errors++;
            $display("FAIL below_min_ignored got period=%0d expected 8", period);
        end
        hold(1'b0, 4);
        push(32'd15, 1'b0);            // measured from the last accepted edge
        hold(1'b1, 500);
        hold(1'b0, 500);
        push(32'd1000, 1'b0);          // spacing exactly MAX: no timeout
        hold(1'b1, 50);
        checks++;
        if (period !== 32'd1000 || silent !== 1'b0) begin
            errors++;
            $display("FAIL max_spacing got period=%0d silent=%0b expected 1000/0", period, silent);
        end
        hold(1'b0, 50);
    endtask

    task test_midreset();
        push(32'd100, 1'b0);
        hold(1'b1, 48);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (period !== 32'd0 || silent !== 1'b1 || period_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state got period=%0d silent=%0b valid=%0b expected 0/1/0",
                     period, silent, period_valid);
        end
        rst = 1'b0;
        hold(1'b1, 1);                 // level still high after release: not an edge
        hold(1'b0, 50);
        hold(1'b1, 50);                // re-arm rise: no strobe
        checks++;
        if (period !== 32'd0 || silent !== 1'b1) begin
            errors++;
            $display("FAIL midreset_rearm got period=%0d silent=%0b expected 0/1", period, silent);
        end
        hold(1'b0, 50);
        push(32'd100, 1'b0);
        hold(1'b1, 50);
        hold(1'b0, 50);
        drain("midreset");
        checks++;
        if (period !== 32'd100 || silent !== 1'b0) begin
            errors++;
            $display("FAIL midreset_recovery got period=%0d silent=%0b expected 100/0", period, silent);
        end
    endtask

    initial begin
        rst     = 1'b1;
        wave_in = 1'b0;
        test_reset();
        test_steady();
        test_glitch();
        test_timeout();
        test_boundaries();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_period_meter.md
Name: wave_period_meter

Overview:
Measures the period of an incoming square wave, such as a comparator-digitised audio input or a looped-back tone output. Period is reported in clk cycles between consecutive rising edges, the same full-cycle count that drives the tone generator's period input, so a measured value can be fed straight back into it. The block sits on the audio input path. It feeds the pitch-matching / scoring logic with a period sample, a valid strobe and a silence flag.

Parameters:
MIN_PERIOD, 1000, minimum accepted edge spacing in clk cycles; closer rising edges are treated as glitches and ignored
MAX_PERIOD, 50_000_000, timeout in clk cycles with no accepted rising edge before the input is declared silent; must be > MIN_PERIOD and < 2^32

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
wave_in  input  1  asynchronous square-wave input
period  output  32  last measured period in clk cycles; 0 when silent
period_valid  output  1  one-cycle strobe: period was just updated (measurement or silence)
silent  output  1  high while no valid periodic input is present

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset values:
  - period=0, period_valid=0, silent=1.
  - FSM=IDLE, cnt=0, synchroniser flops=0.
- Input conditioning:
  - 2-flop synchroniser (s1, s2) plus a history flop s3.
  - rise = s2 & ~s3.
  - Latency from wave_in rising to rise = 2 clk cycles. It is identical for every edge, so it cancels in period measurement.
- Counter: 32-bit cnt, saturating; it never exceeds MAX_PERIOD.
- FSM IDLE (no reference edge yet):
  - On rise: cnt<=1, go to MEASURE. No strobe; two edges are needed for one measurement.
- FSM MEASURE, evaluated each cycle in priority order:
  1. rise && cnt>=MIN_PERIOD: period<=cnt, period_valid<=1, silent<=0, cnt<=1, stay in MEASURE.
  2. rise && cnt<MIN_PERIOD: glitch; edge ignored, cnt<=cnt+1.
  3. cnt==MAX_PERIOD (no accepted rise): period<=0, period_valid<=1, silent<=1, cnt<=0, go to IDLE.
  4. otherwise: cnt<=cnt+1.
- Timing: an accepted rise at cycle t0 followed by the next at t0+N reports period=N at cycle t0+N+1, registered.
- Boundary: a rise exactly at cnt==MAX_PERIOD is accepted (rule 1 beats rule 3), giving period=MAX_PERIOD.
- Boundary: a rise exactly at cnt==MIN_PERIOD is accepted.
- period_valid is high for exactly one cycle per update and never high on consecutive cycles.
  - Minimum spacing between strobes is MIN_PERIOD cycles.
- period holds its value between strobes.
- silent:
  - Falls only on the first accepted measurement.
  - Rises only on timeout or reset.
  - The timeout strobe is issued once; IDLE issues no further strobes.
- Period change: the first interval spanning the change is reported as-is. There is no averaging and no filtering beyond MIN_PERIOD.
- rst asserted mid-measurement:
  - All state returns to reset values on the next edge.
  - Any partial count is discarded.
  - A wave_in level already high at reset release does not count as a rise.
- Duty cycle is irrelevant; only rising edges are used.

Test Plan:
Bench parameters: MIN_PERIOD=8, MAX_PERIOD=1000.
1. Reset: rst high for 3 cycles, wave_in=0 -> period=0, period_valid=0, silent=1 on every cycle, including cycles with rst high.
2. Steady tone: 100-cycle square wave (50 high / 50 low) for 10 periods -> first strobe one cycle after the 2nd synchronised rise; period=100, silent=0. Strobes every 100 cycles, each with period=100.
3. Glitch rejection: in the 100-cycle wave, bounce each rising edge (high 2, low 2, high) -> second rise at cnt=4 ignored; every strobe reports period=100 and no extra strobes occur.
4. Timeout and recovery: stop toggling after a rise -> exactly one strobe 1000 cycles later with period=0, silent=1, then none. Restart a 200-cycle wave -> no strobe on the 1st rise; period=200, silent=0 on the 2nd.
5. Boundaries: edge spacing exactly 8 -> period=8 accepted; spacing 7 -> ignored. Spacing exactly 1000 -> period=1000 with no timeout strobe.
6. Mid-operation reset: 1-cycle rst pulse at cnt≈50 of a 100-cycle wave -> period=0, silent=1. The next rise produces no strobe; the following rise reports period=100.
